reg_access_ctrl: RTL and testbench

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

---
 rtl/reg_access_ctrl_if.sv | 64 ++++++
 rtl/reg_access_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_reg_access_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_ctrl_if.sv
// Register-access controller bus bundle.
// Groups the byte-stream receive side, the register-file side and the
// transmit side into one interface. The "master" modport is the view of the
// controller itself; the "slave" modport is the view of the surrounding
// environment (receiver, register file, transmitter).
interface reg_access_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();

  // Receive side
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;

  // Register-file side
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdData_Valid;
  logic [ADDR_WIDTH-1:0] Address;
  logic                  WrEn;
  logic                  RdEn;
  logic [DATA_WIDTH-1:0] WrData;

  // Transmit side
  logic                  TX_Busy;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;

  // Status
  logic                  Busy;
  logic                  Err;

  modport master (
    input  RX_P_DATA,
    input  RX_D_VLD,
    input  RdData,
    input  RdData_Valid,
    input  TX_Busy,
    output Address,
    output WrEn,
    output RdEn,
    output WrData,
    output TX_P_DATA,
    output TX_D_VLD,
    output Busy,
    output Err
  );

  modport slave (
    output RX_P_DATA,
    output RX_D_VLD,
    output RdData,
    output RdData_Valid,
    output TX_Busy,
    input  Address,
    input  WrEn,
    input  RdEn,
    input  WrData,
    input  TX_P_DATA,
    input  TX_D_VLD,
    input  Busy,
    input  Err
  );

endinterface

// File: rtl/reg_access_ctrl.sv
// Register-access controller.
// Decodes a received byte stream into register-file writes (0xAA, addr, data)
// and reads (0xBB, addr). Read data is returned through the transmit port.
// Every output is driven straight from a flop.
//
// Optional feature: define REG_ACCESS_ERR_EN to answer unknown command bytes
// with an 0xEE error byte and raise Err until that byte has been sent.
// Without the macro unknown bytes are ignored and Err is tied low.
module reg_access_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  reg_access_ctrl_if.master  bus
);

  // FSM encoding
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] TX_SEND = 3'd5;

  // Command bytes
  localparam logic [DATA_WIDTH-1:0] CMD_WR   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD   = DATA_WIDTH'(8'hBB);
`ifdef REG_ACCESS_ERR_EN
  localparam logic [DATA_WIDTH-1:0] ERR_BYTE = DATA_WIDTH'(8'hEE);
`endif

  // RD_WAIT lasts at most 15 cycles (counter values 0..14, the first one
  // being the RdEn cycle); on the last one without read data we give up.
  localparam logic [3:0] TIMEOUT_LAST = 4'd14;

  // Registered state and outputs
  logic [2:0]            state_q;
  logic [3:0]            tmo_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] txdata_q;
  logic                  txvld_q;
  logic                  wren_q;
  logic                  rden_q;
  logic                  busy_q;

  // Next-state values
  logic [2:0]            state_n;
  logic [3:0]            tmo_cnt_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic [DATA_WIDTH-1:0] txdata_n;
  logic                  txvld_n;
  logic                  wren_n;
  logic                  rden_n;
  logic                  busy_n;

`ifdef REG_ACCESS_ERR_EN
  logic                  err_q;
  logic                  err_n;
`endif

  // Handy aliases for the input side
  logic                  rx_vld;
  logic [DATA_WIDTH-1:0] rx_byte;

  assign rx_vld  = bus.RX_D_VLD;
  assign rx_byte = bus.RX_P_DATA;

  // Next-state and next-output decode for the command FSM
  always_comb begin
    state_n   = state_q;
    tmo_cnt_n = tmo_cnt_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    txdata_n  = txdata_q;
    txvld_n   = txvld_q;
    // Strobes are single-cycle pulses: low unless set below
    wren_n    = 1'b0;
    rden_n    = 1'b0;
`ifdef REG_ACCESS_ERR_EN
    err_n     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (rx_vld) begin
          if (rx_byte == CMD_WR) begin
            state_n = WR_ADDR;
          end else if (rx_byte == CMD_RD) begin
            state_n = RD_ADDR;
          end else begin
`ifdef REG_ACCESS_ERR_EN
            // Unknown command: answer with the error byte
            txdata_n = ERR_BYTE;
            txvld_n  = 1'b1;
            err_n    = 1'b1;
            state_n  = TX_SEND;
`endif
          end
        end
      end

      WR_ADDR: begin
        if (rx_vld) begin
          // Only the low address bits are meaningful; the rest are dropped
          addr_n  = rx_byte[ADDR_WIDTH-1:0];
          state_n = WR_DATA;
        end
      end

      WR_DATA: begin
        if (rx_vld) begin
          wdata_n = rx_byte;
          wren_n  = 1'b1;
          state_n = IDLE;
        end
      end

      RD_ADDR: begin
        if (rx_vld) begin
          addr_n    = rx_byte[ADDR_WIDTH-1:0];
          rden_n    = 1'b1;
          tmo_cnt_n = 4'd0;
          state_n   = RD_WAIT;
        end
      end

      RD_WAIT: begin
        // Read data is only looked at once the RdEn pulse has ended, so a
        // stale valid from the register file in the strobe cycle is ignored.
        // Received bytes are dropped here.
        if (!rden_q && bus.RdData_Valid) begin
          txdata_n  = bus.RdData;
          txvld_n   = 1'b1;
          tmo_cnt_n = 4'd0;
          state_n   = TX_SEND;
        end else if (tmo_cnt_q == TIMEOUT_LAST) begin
          tmo_cnt_n = 4'd0;
          state_n   = IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt_q + 4'd1;
        end
      end

      TX_SEND: begin
        // Data and valid stay put until the transmitter takes the byte.
        // Received bytes are dropped here.
        if (!bus.TX_Busy) begin
          txvld_n = 1'b0;
`ifdef REG_ACCESS_ERR_EN
          err_n   = 1'b0;
`endif
          state_n = IDLE;
        end
      end

      default: begin
        state_n   = IDLE;
        tmo_cnt_n = 4'd0;
        txvld_n   = 1'b0;
      end
    endcase

    // Busy mirrors "not IDLE" for the cycle the new state is current
    busy_n = (state_n != IDLE);
  end

  // State and output registers, cleared asynchronously by RST
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      tmo_cnt_q <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      txdata_q  <= '0;
      txvld_q   <= 1'b0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      tmo_cnt_q <= tmo_cnt_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      txdata_q  <= txdata_n;
      txvld_q   <= txvld_n;
      wren_q    <= wren_n;
      rden_q    <= rden_n;
      busy_q    <= busy_n;
    end
  end

`ifdef REG_ACCESS_ERR_EN
  // Error flag register, set on an unknown command, cleared on its transfer
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_n;
    end
  end

  assign bus.Err = err_q;
`else
  assign bus.Err = 1'b0;
`endif

  assign bus.Address   = addr_q;
  assign bus.WrEn      = wren_q;
  assign bus.RdEn      = rden_q;
  assign bus.WrData    = wdata_q;
  assign bus.TX_P_DATA = txdata_q;
  assign bus.TX_D_VLD  = txvld_q;
  assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Testbench for reg_access_ctrl: directed scenarios plus randomized write/read
// commands, with expectations derived from the command protocol rules.
module tb_reg_access_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  reg_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Event counters observed at every active edge
  int           wr_cnt   = 0;
  int           rd_cnt   = 0;
  int           both_cnt = 0;
  int           tx_cnt   = 0;
  logic [DW-1:0] last_tx = '0;
  logic [DW-1:0] last_wr = '0;

  always @(posedge CLK) begin
    if (bus.WrEn) begin
      wr_cnt  <= wr_cnt + 1;
      last_wr <= bus.WrData;
    end
    if (bus.RdEn) rd_cnt <= rd_cnt + 1;
    if (bus.WrEn && bus.RdEn) both_cnt <= both_cnt + 1;
    if (bus.TX_D_VLD && !bus.TX_Busy) begin
      tx_cnt  <= tx_cnt + 1;
      last_tx <= bus.TX_P_DATA;
    end
  end

  // Reference state: what the register-side outputs should currently hold
  logic [AW-1:0] exp_addr  = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [DW-1:0] exp_tx    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input int gap);
    repeat (gap) begin
      bus.RX_D_VLD  = 1'b0;
      bus.RX_P_DATA = DW'($urandom);
      step();
    end
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    step();
    bus.RX_D_VLD  = 1'b0;
  endtask

  // Noise on the receive side while the controller must ignore it
  task automatic rx_noise();
    bus.RX_P_DATA = DW'($urandom);
    bus.RX_D_VLD  = 1'($urandom);
  endtask

  task automatic do_write(input logic [DW-1:0] a, input logic [DW-1:0] d, input int gap);
    int wr0, rd0;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    send_byte(8'hAA, gap);
    send_byte(a, gap);
    send_byte(d, gap);
    exp_addr  = a[AW-1:0];
    exp_wdata = d;
    chk("wr_wren_high", 32'(bus.WrEn), 32'd1);
    chk("wr_address",   32'(bus.Address), 32'(exp_addr));
    chk("wr_wrdata",    32'(bus.WrData), 32'(exp_wdata));
    chk("wr_rden_low",  32'(bus.RdEn), 32'd0);
    chk("wr_busy_low",  32'(bus.Busy), 32'd0);
    step();
    chk("wr_wren_pulse", 32'(bus.WrEn), 32'd0);
    chk("wr_count",      32'(wr_cnt - wr0), 32'd1);
    chk("wr_no_read",    32'(rd_cnt - rd0), 32'd0);
    chk("wr_last_data",  32'(last_wr), 32'(d));
  endtask

  // delay: cycles after the RdEn cycle at which the responder raises valid
  // (values above 14 mean it never answers); nbusy: transmitter-busy cycles
  task automatic do_read(input logic [DW-1:0] a, input int delay, input int nbusy,
                         input logic [DW-1:0] d, input int gap);
    int  rd0, tx0, wr0;
    bit  answered;
    rd0 = rd_cnt;
    tx0 = tx_cnt;
    wr0 = wr_cnt;
    answered = (delay >= 1) && (delay <= 14);
    send_byte(8'hBB, gap);
    send_byte(a, 0);
    exp_addr = a[AW-1:0];
    chk("rd_rden_high", 32'(bus.RdEn), 32'd1);
    chk("rd_address",   32'(bus.Address), 32'(exp_addr));
    chk("rd_wren_low",  32'(bus.WrEn), 32'd0);
    // A valid in the strobe cycle itself must not be taken
    bus.RdData_Valid = 1'($urandom);
    bus.RdData       = d ^ 8'h5A;
    bus.TX_Busy      = 1'($urandom);
    rx_noise();
    step();
    if (answered) begin
      for (int k = 1; k <= delay; k++) begin
        bus.RdData_Valid = (k == delay);
        bus.RdData       = (k == delay) ? d : DW'($urandom);
        rx_noise();
        step();
      end
      bus.RdData_Valid = 1'b0;
      exp_tx = d;
      for (int i = 0; i <= nbusy; i++) begin
        bus.TX_Busy = (i < nbusy);
        rx_noise();
        chk("rd_txvld_hold",  32'(bus.TX_D_VLD), 32'd1);
        chk("rd_txdata_hold", 32'(bus.TX_P_DATA), 32'(exp_tx));
        chk("rd_busy_hold",   32'(bus.Busy), 32'd1);
        step();
      end
      bus.TX_Busy  = 1'b0;
      bus.RX_D_VLD = 1'b0;
      chk("rd_txvld_clear", 32'(bus.TX_D_VLD), 32'd0);
      chk("rd_busy_clear",  32'(bus.Busy), 32'd0);
      chk("rd_tx_count",    32'(tx_cnt - tx0), 32'd1);
      chk("rd_tx_byte",     32'(last_tx), 32'(d));
    end else begin
      bus.RdData_Valid = 1'b0;
      for (int k = 1; k < 14; k++) begin
        rx_noise();
        chk("to_txvld_low", 32'(bus.TX_D_VLD), 32'd0);
        step();
      end
      chk("to_busy_waiting", 32'(bus.Busy), 32'd1);
      rx_noise();
      step();
      bus.RX_D_VLD = 1'b0;
      bus.TX_Busy  = 1'b0;
      chk("to_busy_clear", 32'(bus.Busy), 32'd0);
      chk("to_txvld_low2", 32'(bus.TX_D_VLD), 32'd0);
      chk("to_tx_none",    32'(tx_cnt - tx0), 32'd0);
    end
    chk("rd_count",    32'(rd_cnt - rd0), 32'd1);
    chk("rd_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("rd_wrdata_held", 32'(bus.WrData), 32'(exp_wdata));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_address"}, 32'(bus.Address), 32'd0);
    chk({tag, "_wrdata"},  32'(bus.WrData), 32'd0);
    chk({tag, "_txdata"},  32'(bus.TX_P_DATA), 32'd0);
    chk({tag, "_wren"},    32'(bus.WrEn), 32'd0);
    chk({tag, "_rden"},    32'(bus.RdEn), 32'd0);
    chk({tag, "_txvld"},   32'(bus.TX_D_VLD), 32'd0);
    chk({tag, "_busy"},    32'(bus.Busy), 32'd0);
    chk({tag, "_err"},     32'(bus.Err), 32'd0);
  endtask

  initial begin
    int wr0, tx0;
    bus.RX_P_DATA    = '0;
    bus.RX_D_VLD     = 1'b0;
    bus.RdData       = '0;
    bus.RdData_Valid = 1'b0;
    bus.TX_Busy      = 1'b0;

    // Power-on reset
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("rst");
    @(negedge CLK);
    RST = 1'b1;
    step();

    // Basic write: 0xAA, 0x05, 0x3C
    do_write(8'h05, 8'h3C, 0);

    // Basic read answered the cycle after RdEn
    do_read(8'h05, 1, 0, 8'h3C, 0);

    // Read with the transmitter busy for 10 cycles
    do_read(8'h0A, 1, 10, 8'hC3, 1);

    // Read that is never answered
    do_read(8'h03, 99, 0, 8'h00, 0);

    // Upper address bits are ignored
    do_write(8'hF9, 8'h81, 2);
    chk("addr_trunc", 32'(bus.Address), 32'd9);

    // Randomized commands, back-to-back or with gaps
    for (int n = 0; n < 24; n++) begin
      int kind;
      kind = int'($urandom_range(0, 4));
      if (kind <= 1) begin
        do_write(DW'($urandom), DW'($urandom), int'($urandom_range(0, 2)));
      end else if (kind <= 3) begin
        do_read(DW'($urandom), int'($urandom_range(1, 14)), int'($urandom_range(0, 5)),
                DW'($urandom), int'($urandom_range(0, 2)));
      end else begin
        do_read(DW'($urandom), 15, 0, DW'($urandom), int'($urandom_range(0, 2)));
      end
      chk("hold_address", 32'(bus.Address), 32'(exp_addr));
      chk("hold_wrdata",  32'(bus.WrData), 32'(exp_wdata));
    end

    // Make sure data registers are non-zero before the reset test
    do_write(8'h06, 8'h77, 0);
    do_read(8'h06, 2, 0, 8'h99, 0);

    // Reset in the middle of a write command
    wr0 = wr_cnt;
    send_byte(8'hAA, 0);
    send_byte(8'h07, 0);
    chk("mid_busy",    32'(bus.Busy), 32'd1);
    chk("mid_address", 32'(bus.Address), 32'd7);
    #2;
    RST = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge CLK);
    RST = 1'b1;
    exp_addr  = '0;
    exp_wdata = '0;
    step();
    send_byte(8'h11, 0);
    repeat (3) step();
    chk("post_rst_no_wren", 32'(wr_cnt - wr0), 32'd0);
    chk("post_rst_busy",    32'(bus.Busy), 32'd0);
    chk("post_rst_addr",    32'(bus.Address), 32'd0);
    chk("post_rst_wrdata",  32'(bus.WrData), 32'd0);

    // Unknown command byte in IDLE
    tx0 = tx_cnt;
    wr0 = wr_cnt;
    send_byte(8'h55, 0);
`ifdef REG_ACCESS_ERR_EN
    chk("err_set",     32'(bus.Err), 32'd1);
    chk("err_txvld",   32'(bus.TX_D_VLD), 32'd1);
    chk("err_txdata",  32'(bus.TX_P_DATA), 32'hEE);
    chk("err_busy",    32'(bus.Busy), 32'd1);
    step();
    chk("err_clear",   32'(bus.Err), 32'd0);
    chk("err_txdone",  32'(bus.TX_D_VLD), 32'd0);
    chk("err_txcount", 32'(tx_cnt - tx0), 32'd1);
    chk("err_txbyte",  32'(last_tx), 32'hEE);
`else
    chk("unk_err",    32'(bus.Err), 32'd0);
    chk("unk_busy",   32'(bus.Busy), 32'd0);
    chk("unk_txvld",  32'(bus.TX_D_VLD), 32'd0);
    repeat (2) step();
    chk("unk_txcount", 32'(tx_cnt - tx0), 32'd0);
`endif
    chk("unk_no_wren", 32'(wr_cnt - wr0), 32'd0);

    // Controller still works afterwards
    do_write(8'h02, 8'h5D, 0);

    chk("never_wr_and_rd", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
